ddr3_burst_reader: RTL and testbench

Avalon-MM burst read master that fetches a contiguous block of words from the DDR3 controller and delivers them, in address order, on a ready/valid stream to the matrix-multiply datapath. Software or a sequencer supplies a base address and a word count, then pulses `start`. The block issues read bursts only when its receive FIFO has room for every outstanding word, so it never back-pressures `avm_readdatavalid`.

---
 rtl/mm_pkg.sv | 15 +
 rtl/ddr3_burst_reader_if.sv | 42 ++++
 rtl/ddr3_burst_reader_sync_fifo.sv | 88 ++++++++
 rtl/ddr3_burst_reader.sv | 152 +++++++++++++++
 tb/tb_ddr3_burst_reader.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply memory path: reader FSM states
// and the word/burst sizes the datapath is built around.
package mm_pkg;

    localparam int MM_DATA_W    = 64;
    localparam int MM_MAX_BURST = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/ddr3_burst_reader_if.sv
// Avalon-MM burst read port plus the outgoing word stream of the burst reader.
//
// Handshakes: an Avalon read is accepted in a cycle where avm_read=1 and
// avm_waitrequest=0; address and burstcount are held while waitrequest=1.
// avm_readdatavalid qualifies one returned word per cycle and is never stalled.
// A stream word moves in a cycle where st_valid=1 and st_ready=1; once raised,
// st_valid and st_data stay put until that handshake.
interface ddr3_burst_reader_if
    import mm_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = MM_DATA_W,
    parameter int MAX_BURST = MM_MAX_BURST
) ();

    localparam int BC_W = $clog2(MAX_BURST) + 1;

    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic [BC_W-1:0]   avm_burstcount;
    logic              avm_waitrequest;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_readdatavalid;
    logic [DATA_W-1:0] st_data;
    logic              st_valid;
    logic              st_ready;

    modport master (
        output avm_address, avm_read, avm_burstcount,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid,
        output st_data, st_valid,
        input  st_ready
    );

    modport slave (
        input  avm_address, avm_read, avm_burstcount,
        output avm_waitrequest, avm_readdata, avm_readdatavalid,
        input  st_data, st_valid,
        output st_ready
    );

endinterface

// File: rtl/ddr3_burst_reader_sync_fifo.sv
// First-word-fall-through receive FIFO. Writes land in an input register,
// then either go straight to the registered output (when it is free and the
// array is empty) or into the array. o_count covers every stored word,
// including the input and output registers, so the producer can budget space.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 32,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_rd_valid,
    output logic [CNT_W-1:0] o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_mem_count;
    logic             r_in_valid;
    logic [WIDTH-1:0] r_in_data;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;

    logic w_pop;
    logic w_out_free;
    logic w_mem_empty;
    logic w_from_mem;
    logic w_bypass;
    logic w_mem_wr;

    assign w_pop       = i_rd_en & r_out_valid;
    assign w_out_free  = ~r_out_valid | w_pop;
    assign w_mem_empty = (r_mem_count == '0);
    assign w_from_mem  = w_out_free & ~w_mem_empty;
    assign w_bypass    = w_out_free & w_mem_empty & r_in_valid;
    assign w_mem_wr    = r_in_valid & ~w_bypass;

    assign o_rd_data  = r_out_data;
    assign o_rd_valid = r_out_valid;
    assign o_count    = r_mem_count + CNT_W'(r_out_valid) + CNT_W'(r_in_valid);

    // Storage array: contents need no reset, the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_mem_wr) begin
            r_mem[r_wr_ptr] <= r_in_data;
        end
    end

    // Input register, pointers, occupancy and the registered output word.
    always_ff @(posedge clk) begin
        r_in_data <= i_wr_data;
        if (reset) begin
            r_in_valid  <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_mem_count <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_in_valid <= i_wr_en;
            if (w_mem_wr) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_from_mem) begin
                r_rd_ptr   <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
                r_out_data <= r_mem[r_rd_ptr];
            end else if (w_bypass) begin
                r_out_data <= r_in_data;
            end
            if (w_out_free) begin
                r_out_valid <= w_from_mem | w_bypass;
            end
            case ({w_mem_wr, w_from_mem})
                2'b10:   r_mem_count <= r_mem_count + 1'b1;
                2'b01:   r_mem_count <= r_mem_count - 1'b1;
                default: r_mem_count <= r_mem_count;
            endcase
        end
    end

endmodule

// File: rtl/ddr3_burst_reader.sv
// Avalon-MM burst read master: fetches `length` words from base_addr and
// streams them out in address order. A burst is only issued when the receive
// FIFO has room for it plus everything already in flight, so returned data
// never needs to be back-pressured.
module ddr3_burst_reader
    import mm_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = MM_DATA_W,
    parameter int MAX_BURST  = MM_MAX_BURST,
    parameter int FIFO_DEPTH = 32,
    parameter int LEN_W      = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [LEN_W-1:0]    length,
    output logic                busy,
    output logic                done,
    output state_t              o_dbg_state,
    ddr3_burst_reader_if.master bus
);

    localparam int BC_W    = $clog2(MAX_BURST) + 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int ROOM_W  = CNT_W + 1;
    localparam int BYTE_SH = $clog2(DATA_W / 8);

    state_t            r_state;
    state_t            w_next_state;
    logic [LEN_W-1:0]  r_req_left;
    logic [LEN_W-1:0]  r_rx_left;
    logic [CNT_W-1:0]  r_outstanding;
    logic [ADDR_W-1:0] r_addr;

    logic [BC_W-1:0]   w_b;
    logic [CNT_W-1:0]  w_fifo_count;
    logic [ROOM_W-1:0] w_used;
    logic [ROOM_W-1:0] w_room;
    logic              w_room_ok;
    logic              w_issue;
    logic              w_accept;
    logic              w_fifo_valid;
    logic              w_st_hs;
    logic              w_load;

    // Next burst size: a full burst, or whatever is left of the job.
    assign w_b = (r_req_left >= LEN_W'(MAX_BURST)) ? BC_W'(MAX_BURST) : BC_W'(r_req_left);

    // Free space counts words buffered and words still owed by the controller.
    assign w_used    = ROOM_W'(w_fifo_count) + ROOM_W'(r_outstanding);
    assign w_room    = ROOM_W'(FIFO_DEPTH) - w_used;
    assign w_room_ok = (w_room >= ROOM_W'(w_b));

    assign w_accept = w_issue & ~bus.avm_waitrequest;
    assign w_st_hs  = w_fifo_valid & bus.st_ready;
    assign w_load   = (r_state == IDLE) && start && (length != '0);

    // Request fields only move on accept and free space only grows while
    // stalled, so these stay stable through waitrequest.
    assign bus.avm_read       = w_issue;
    assign bus.avm_address    = w_issue ? r_addr : '0;
    assign bus.avm_burstcount = w_issue ? w_b : '0;
    assign bus.st_valid       = w_fifo_valid;
    assign o_dbg_state        = r_state;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic, burst request and status outputs.
    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = (length != '0) ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                busy    = 1'b1;
                w_issue = w_room_ok;
                if (w_issue && !bus.avm_waitrequest && (r_req_left == LEN_W'(w_b))) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                // Leave on the final handshake itself so done follows it directly.
                if ((r_rx_left == '0) || ((r_rx_left == LEN_W'(1)) && w_st_hs)) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                done         = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Job counters, burst address and in-flight word accounting.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_req_left    <= '0;
            r_rx_left     <= '0;
            r_outstanding <= '0;
            r_addr        <= '0;
        end else begin
            if (w_load) begin
                r_req_left <= length;
                r_rx_left  <= length;
                r_addr     <= base_addr & ~ADDR_W'(DATA_W / 8 - 1);
            end else begin
                if (w_accept) begin
                    r_req_left <= r_req_left - LEN_W'(w_b);
                    r_addr     <= r_addr + (ADDR_W'(w_b) << BYTE_SH);
                end
                if (w_st_hs) begin
                    r_rx_left <= r_rx_left - LEN_W'(1);
                end
            end
            r_outstanding <= r_outstanding + (w_accept ? CNT_W'(w_b) : CNT_W'(0))
                             - CNT_W'(bus.avm_readdatavalid);
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_wr_en    (bus.avm_readdatavalid),
        .i_wr_data  (bus.avm_readdata),
        .i_rd_en    (bus.st_ready),
        .o_rd_data  (bus.st_data),
        .o_rd_valid (w_fifo_valid),
        .o_count    (w_fifo_count)
    );

endmodule

// File: tb/tb_ddr3_burst_reader.sv
// Directed bench for ddr3_burst_reader: a zero-latency Avalon slave model with
// optional stalls, an expected-burst queue checked on every accept, and an
// expected-word queue checked on every stream handshake.
module tb_ddr3_burst_reader;
    import mm_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] length;
    logic        busy;
    logic        done;
    state_t      dbg_state;

    ddr3_burst_reader_if #(.ADDR_W(32), .DATA_W(64), .MAX_BURST(8)) bus ();

    ddr3_burst_reader #(
        .ADDR_W(32), .DATA_W(64), .MAX_BURST(8), .FIFO_DEPTH(32), .LEN_W(16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .base_addr   (base_addr),
        .length      (length),
        .busy        (busy),
        .done        (done),
        .o_dbg_state (dbg_state),
        .bus         (bus)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];
    logic [31:0] exp_addr_q[$];
    logic [3:0]  exp_bc_q[$];
    logic [31:0] rsp_q[$];

    int   job_id       = 0;
    int   stall_burst  = -1;
    int   stall_cycles = 0;
    int   seen_job     = 0;
    int   burst_cnt    = 0;
    int   stall_left   = 0;
    int   stall_hits   = 0;
    int   words_req    = 0;
    int   read_cycles  = 0;
    int   done_cnt     = 0;
    logic prev_done    = 1'b0;
    logic        held_valid = 1'b0;
    logic [31:0] held_addr;
    logic [3:0]  held_bc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mem_word(input logic [31:0] a);
        return {a ^ 32'hDEAD_BEEF, a};
    endfunction

    task automatic push_burst(input logic [31:0] a, input logic [3:0] bc);
        exp_addr_q.push_back(a);
        exp_bc_q.push_back(bc);
    endtask

    task automatic push_words(input logic [31:0] a, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(mem_word(a + 32'(i * 8)));
    endtask

    // ---------------- Avalon slave model ----------------
    // Responses start the cycle after a burst is accepted, one word per cycle.
    always @(negedge clk) begin
        if (reset) begin
            rsp_q.delete();
            bus.avm_readdatavalid = 1'b0;
            bus.avm_readdata      = '0;
            bus.avm_waitrequest   = 1'b0;
            held_valid            = 1'b0;
        end else begin
            if (job_id != seen_job) begin
                seen_job   = job_id;
                burst_cnt  = 0;
                stall_left = stall_cycles;
            end
            if (rsp_q.size() > 0) begin
                bus.avm_readdatavalid = 1'b1;
                bus.avm_readdata      = mem_word(rsp_q.pop_front());
            end else begin
                bus.avm_readdatavalid = 1'b0;
                bus.avm_readdata      = '0;
            end
            if (bus.avm_read) begin
                read_cycles++;
                if (burst_cnt == stall_burst && stall_left > 0) begin
                    bus.avm_waitrequest = 1'b1;
                    stall_left--;
                    stall_hits++;
                    if (held_valid) begin
                        check("stall_addr_stable", bus.avm_address, held_addr);
                        check("stall_bc_stable", bus.avm_burstcount, held_bc);
                    end else begin
                        held_valid = 1'b1;
                        held_addr  = bus.avm_address;
                        held_bc    = bus.avm_burstcount;
                    end
                end else begin
                    bus.avm_waitrequest = 1'b0;
                    if (held_valid) begin
                        check("accept_addr_after_stall", bus.avm_address, held_addr);
                        held_valid = 1'b0;
                    end
                    if (exp_addr_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL burst_extra: got burst %0d@%0h, expected none",
                                 bus.avm_burstcount, bus.avm_address);
                    end else begin
                        check("burst_addr", bus.avm_address, exp_addr_q.pop_front());
                        check("burst_count", bus.avm_burstcount, exp_bc_q.pop_front());
                    end
                    for (int i = 0; i < int'(bus.avm_burstcount); i++)
                        rsp_q.push_back(bus.avm_address + 32'(i * 8));
                    words_req += int'(bus.avm_burstcount);
                    burst_cnt++;
                end
            end else begin
                bus.avm_waitrequest = 1'b0;
                if (held_valid) begin
                    check("stall_read_held", bus.avm_read, 1);
                    held_valid = 1'b0;
                end
            end
        end
    end

    // ---------------- stream / done monitor ----------------
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.st_valid && bus.st_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL st_extra: got word %0h, expected none", bus.st_data);
                end else begin
                    check("st_data", bus.st_data, exp_q.pop_front());
                end
            end
            if (done) begin
                done_cnt++;
                check("busy_low_at_done", busy, 0);
                check("done_one_cycle", prev_done, 0);
            end
        end
        prev_done = done;
    end

    // ---------------- driver tasks ----------------
    task automatic run_job(input logic [31:0] base, input logic [15:0] len);
        @(posedge clk); #1;
        job_id++;
        base_addr = base;
        length    = len;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int target, input int budget);
        int cyc = 0;
        while (done_cnt < target && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check(name, (done_cnt >= target) ? 64'd1 : 64'd0, 64'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int d0;
        int w0;
        int r0;
        int cyc;

        reset        = 1'b1;
        start        = 1'b0;
        base_addr    = '0;
        length       = '0;
        bus.st_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_avm_read", bus.avm_read, 0);
        check("rst_st_valid", bus.st_valid, 0);
        check("rst_avm_address", bus.avm_address, 0);
        check("rst_avm_burstcount", bus.avm_burstcount, 0);
        check("rst_st_data", bus.st_data, 0);
        check("rst_state", dbg_state, IDLE);
        @(posedge clk); #1;
        reset = 1'b0;

        // 20 words from 0x1000, free-running stream: 8 + 8 + 4.
        bus.st_ready = 1'b1;
        d0 = done_cnt;
        push_burst(32'h1000, 4'd8);
        push_burst(32'h1040, 4'd8);
        push_burst(32'h1080, 4'd4);
        push_words(32'h1000, 20);
        run_job(32'h1000, 16'd20);
        wait_done("t1_done_seen", d0 + 1, 300);
        repeat (5) @(negedge clk);
        check("t1_done_count", done_cnt, d0 + 1);
        check("t1_words_left", exp_q.size(), 0);
        check("t1_bursts_left", exp_addr_q.size(), 0);

        // Zero-length job: no reads; done occupies the clock period right after
        // the edge that samples start (the second period counted from the edge
        // that raised start).
        d0 = done_cnt;
        r0 = read_cycles;
        @(posedge clk); #1;
        job_id++;
        length = '0;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("t2_done_timing", done, 1);
        repeat (4) @(negedge clk);
        check("t2_no_read", read_cycles - r0, 0);
        check("t2_done_count", done_cnt, d0 + 1);

        // 64 words with the stream stalled: only a FIFO's worth is requested.
        bus.st_ready = 1'b0;
        d0 = done_cnt;
        w0 = words_req;
        for (int i = 0; i < 8; i++) push_burst(32'h4000 + 32'(i * 64), 4'd8);
        push_words(32'h4000, 64);
        run_job(32'h4000, 16'd64);
        repeat (80) @(negedge clk);
        check("t3_words_requested_stalled", words_req - w0, 32);
        check("t3_read_low", bus.avm_read, 0);
        check("t3_state_issue", dbg_state, ISSUE);
        @(posedge clk); #1;
        bus.st_ready = 1'b1;
        wait_done("t3_done_seen", d0 + 1, 500);
        check("t3_words_requested_total", words_req - w0, 64);
        check("t3_words_left", exp_q.size(), 0);

        // Five waitrequest cycles on the second of three bursts.
        stall_burst  = 1;
        stall_cycles = 5;
        d0 = done_cnt;
        w0 = words_req;
        cyc = stall_hits;
        push_burst(32'h3000, 4'd8);
        push_burst(32'h3040, 4'd8);
        push_burst(32'h3080, 4'd8);
        push_words(32'h3000, 24);
        run_job(32'h3000, 16'd24);
        wait_done("t4_done_seen", d0 + 1, 300);
        check("t4_stall_cycles", stall_hits - cyc, 5);
        check("t4_words_requested", words_req - w0, 24);
        check("t4_bursts_left", exp_addr_q.size(), 0);
        stall_burst  = -1;
        stall_cycles = 0;

        // Unaligned base 0x5003 reads from 0x5000; a second start while busy is dropped.
        d0 = done_cnt;
        w0 = words_req;
        push_burst(32'h5000, 4'd8);
        push_burst(32'h5040, 4'd8);
        push_words(32'h5000, 16);
        run_job(32'h5003, 16'd16);
        repeat (2) @(posedge clk);
        #1;
        base_addr = 32'h9000;
        length    = 16'd5;
        start     = 1'b1;
        @(negedge clk);
        check("t5_busy_at_restart", busy, 1);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("t5_done_seen", d0 + 1, 300);
        repeat (10) @(negedge clk);
        check("t5_done_count", done_cnt, d0 + 1);
        check("t5_words_requested", words_req - w0, 16);
        check("t5_words_left", exp_q.size(), 0);

        // Reset while draining, then a clean 8-word job.
        bus.st_ready = 1'b0;
        push_burst(32'h6000, 4'd8);
        run_job(32'h6000, 16'd8);
        cyc = 0;
        while (dbg_state != DRAIN && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("t6_reached_drain", dbg_state, DRAIN);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t6_state_idle", dbg_state, IDLE);
        check("t6_st_valid", bus.st_valid, 0);
        check("t6_busy", busy, 0);
        exp_q.delete();
        @(posedge clk); #1;
        reset        = 1'b0;
        bus.st_ready = 1'b1;
        d0 = done_cnt;
        push_burst(32'h2000, 4'd8);
        push_words(32'h2000, 8);
        run_job(32'h2000, 16'd8);
        wait_done("t6_done_seen", d0 + 1, 200);
        repeat (5) @(negedge clk);
        check("t6_done_count", done_cnt, d0 + 1);
        check("t6_words_left", exp_q.size(), 0);
        check("final_bursts_left", exp_addr_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
